// File: rtl/json_pkg.sv
// Shared definitions for the JSON stream parser: FSM state codes,
// ASCII token constants and character-class helpers.
package json_pkg;

    localparam int unsigned ST_W = 4;

    // FSM state encodings
    localparam logic [ST_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [ST_W-1:0] ST_OPEN    = 4'd1;
    localparam logic [ST_W-1:0] ST_KEY     = 4'd2;
    localparam logic [ST_W-1:0] ST_KEY_END = 4'd3;
    localparam logic [ST_W-1:0] ST_COLON   = 4'd4;
    localparam logic [ST_W-1:0] ST_VSTR    = 4'd5;
    localparam logic [ST_W-1:0] ST_NUM     = 4'd6;
    localparam logic [ST_W-1:0] ST_VAL_END = 4'd7;
    localparam logic [ST_W-1:0] ST_COMMA   = 4'd8;

    // ASCII tokens
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_id(input logic [7:0] c);
        return is_digit(c) ||
               ((c >= 8'h41) && (c <= 8'h5A)) ||
               ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

endpackage

// File: rtl/json_char_class.sv
// Combinational character classifier.
// Ports: char (ASCII in), is_id ([A-Za-z0-9]), is_digit ([0-9]),
//        digit_val (numeric value, meaningful only when is_digit).
module json_char_class (
    input  logic [7:0] char,
    output logic       is_id,
    output logic       is_digit,
    output logic [3:0] digit_val
);

    assign is_id     = json_pkg::is_id(char);
    assign is_digit  = json_pkg::is_digit(char);
    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the value
    assign digit_val = char[3:0];

endmodule

// File: rtl/json_stream_parser.sv
// Streaming validator for flat JSON objects with string or unsigned
// decimal values. Reports pair count, running max pair count and the
// saturating numeric sum of each valid object.
// Ports: clk, reset (sync, active-high), char_valid/char (input stream),
//        cur_num, max_num, num_sum (results), obj_done/obj_err (pulses),
//        busy (inside an object).
module json_stream_parser
    import json_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned NUM_W    = 16,
    parameter int unsigned ALLOW_WS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             char_valid,
    input  logic [7:0]       char,
    output logic [CNT_W-1:0] cur_num,
    output logic [CNT_W-1:0] max_num,
    output logic [NUM_W-1:0] num_sum,
    output logic             obj_done,
    output logic             obj_err,
    output logic             busy
);

    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned PROD_W = NUM_W + 4;

    logic [ST_W-1:0]  state, state_n;
    logic [CNT_W-1:0] pairs, pairs_n;
    logic [NUM_W-1:0] sum, sum_n;
    logic [NUM_W-1:0] acc, acc_n;
    logic [LEN_W-1:0] len, len_n;
    logic             lead_zero, lead_zero_n;
    logic [CNT_W-1:0] cur_num_n, max_num_n;
    logic [NUM_W-1:0] num_sum_n;
    logic             done_n, err_n;

    logic             cc_is_id, cc_is_digit;
    logic [3:0]       cc_digit;

    json_char_class u_cc (
        .char      (char),
        .is_id     (cc_is_id),
        .is_digit  (cc_is_digit),
        .digit_val (cc_digit)
    );

    // Value-completion helpers: saturating pair increment and sum add
    logic [CNT_W-1:0]  pairs_inc;
    logic [NUM_W:0]    sum_wide;
    logic [NUM_W-1:0]  sum_add;
    logic [PROD_W-1:0] prod;
    logic              prod_ovf;
    logic              ws;

    assign pairs_inc = (&pairs) ? pairs : pairs + CNT_W'(1);
    assign sum_wide  = {1'b0, sum} + {1'b0, acc};
    assign sum_add   = sum_wide[NUM_W] ? {NUM_W{1'b1}} : sum_wide[NUM_W-1:0];
    assign prod      = PROD_W'(acc) * PROD_W'(10) + PROD_W'(cc_digit);
    assign prod_ovf  = |prod[PROD_W-1:NUM_W];
    assign ws        = (char == CH_SPACE) && (ALLOW_WS != 0);

    // Next-state, datapath and result computation
    always_comb begin
        state_n     = state;
        pairs_n     = pairs;
        sum_n       = sum;
        acc_n       = acc;
        len_n       = len;
        lead_zero_n = lead_zero;
        cur_num_n   = cur_num;
        max_num_n   = max_num;
        num_sum_n   = num_sum;
        done_n      = 1'b0;
        err_n       = 1'b0;

        if (char_valid) begin
            case (state)
                ST_IDLE: begin
                    if (char == CH_LBRACE) begin
                        state_n     = ST_OPEN;
                        pairs_n     = '0;
                        sum_n       = '0;
                        acc_n       = '0;
                        len_n       = '0;
                        lead_zero_n = 1'b0;
                    end
                end
                ST_OPEN: begin
                    if (char == CH_QUOTE) begin
                        state_n = ST_KEY;
                        len_n   = '0;
                    end else if (char == CH_RBRACE) done_n = 1'b1;
                    else if (!ws)                   err_n  = 1'b1;
                end
                ST_KEY, ST_VSTR: begin
                    if (cc_is_id) begin
                        if (len == LEN_W'(MAX_LEN)) err_n = 1'b1;
                        else                        len_n = len + LEN_W'(1);
                    end else if (char == CH_QUOTE && len != '0) begin
                        if (state == ST_KEY) state_n = ST_KEY_END;
                        else begin
                            state_n = ST_VAL_END;
                            pairs_n = pairs_inc;
                        end
                    end else err_n = 1'b1;
                end
                ST_KEY_END: begin
                    if (char == CH_COLON) state_n = ST_COLON;
                    else if (!ws)         err_n   = 1'b1;
                end
                ST_COLON: begin
                    if (char == CH_QUOTE) begin
                        state_n = ST_VSTR;
                        len_n   = '0;
                    end else if (cc_is_digit) begin
                        state_n     = ST_NUM;
                        acc_n       = NUM_W'(cc_digit);
                        lead_zero_n = (cc_digit == 4'd0);
                    end else if (!ws) err_n = 1'b1;
                end
                ST_NUM: begin
                    if (cc_is_digit) begin
                        if (lead_zero || prod_ovf) err_n = 1'b1;
                        else                       acc_n = NUM_W'(prod);
                    end else if (char == CH_COMMA || char == CH_RBRACE || ws) begin
                        pairs_n = pairs_inc;
                        sum_n   = sum_add;
                        if (char == CH_COMMA)       state_n = ST_COMMA;
                        else if (char == CH_RBRACE) done_n  = 1'b1;
                        else                        state_n = ST_VAL_END;
                    end else err_n = 1'b1;
                end
                ST_VAL_END: begin
                    if (char == CH_COMMA)       state_n = ST_COMMA;
                    else if (char == CH_RBRACE) done_n  = 1'b1;
                    else if (!ws)               err_n   = 1'b1;
                end
                ST_COMMA: begin
                    if (char == CH_QUOTE) begin
                        state_n = ST_KEY;
                        len_n   = '0;
                    end else if (!ws) err_n = 1'b1;
                end
                default: state_n = ST_IDLE;
            endcase

            // Publish results using the already-updated pair/sum values
            if (done_n) begin
                state_n   = ST_IDLE;
                cur_num_n = pairs_n;
                num_sum_n = sum_n;
                max_num_n = (pairs_n > max_num) ? pairs_n : max_num;
            end
            if (err_n) state_n = ST_IDLE;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pairs     <= '0;
            sum       <= '0;
            acc       <= '0;
            len       <= '0;
            lead_zero <= 1'b0;
            cur_num   <= '0;
            max_num   <= '0;
            num_sum   <= '0;
            obj_done  <= 1'b0;
            obj_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            pairs     <= pairs_n;
            sum       <= sum_n;
            acc       <= acc_n;
            len       <= len_n;
            lead_zero <= lead_zero_n;
            cur_num   <= cur_num_n;
            max_num   <= max_num_n;
            num_sum   <= num_sum_n;
            obj_done  <= done_n;
            obj_err   <= err_n;
            busy      <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_json_stream_parser.sv
// Directed self-checking bench for json_stream_parser. Three instances
// share one input stream: defaults, NUM_W=8, and ALLOW_WS=0; each
// section resets and checks only the instance it targets.
module tb_json_stream_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic       char_valid;
    logic [7:0] char;

    logic [7:0]  d_cur, d_max, n_cur, n_max, w_cur, w_max;
    logic [15:0] d_sum, w_sum;
    logic [7:0]  n_sum;
    logic        d_done, d_err, d_busy;
    logic        n_done, n_err, n_busy;
    logic        w_done, w_err, w_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    json_stream_parser u_def (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
        .cur_num(d_cur), .max_num(d_max), .num_sum(d_sum),
        .obj_done(d_done), .obj_err(d_err), .busy(d_busy)
    );

    json_stream_parser #(.NUM_W(8)) u_n8 (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
        .cur_num(n_cur), .max_num(n_max), .num_sum(n_sum),
        .obj_done(n_done), .obj_err(n_err), .busy(n_busy)
    );

    json_stream_parser #(.ALLOW_WS(0)) u_nws (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
        .cur_num(w_cur), .max_num(w_max), .num_sum(w_sum),
        .obj_done(w_done), .obj_err(w_err), .busy(w_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // dut: 0 = defaults, 1 = NUM_W=8, 2 = ALLOW_WS=0
    task automatic chk_res(input string tag, input int dut,
                           input logic [31:0] cur, input logic [31:0] mx,
                           input logic [31:0] sum, input logic done,
                           input logic err, input logic bsy);
        logic [31:0] oc, om, os;
        logic od, oe, ob;
        case (dut)
            0: begin oc = 32'(d_cur); om = 32'(d_max); os = 32'(d_sum); od = d_done; oe = d_err; ob = d_busy; end
            1: begin oc = 32'(n_cur); om = 32'(n_max); os = 32'(n_sum); od = n_done; oe = n_err; ob = n_busy; end
            default: begin oc = 32'(w_cur); om = 32'(w_max); os = 32'(w_sum); od = w_done; oe = w_err; ob = w_busy; end
        endcase
        chk({tag, ".cur_num"},  oc, cur);
        chk({tag, ".max_num"},  om, mx);
        chk({tag, ".num_sum"},  os, sum);
        chk({tag, ".obj_done"}, 32'(od), 32'(done));
        chk({tag, ".obj_err"},  32'(oe), 32'(err));
        chk({tag, ".busy"},     32'(ob), 32'(bsy));
    endtask

    task automatic send_char(input logic [7:0] c);
        char       = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    // Each character followed by one idle (char_valid=0) cycle
    task automatic send_gapped(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            if (i != s.len() - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        char_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_res("reset", 0, 0, 0, 0, 0, 0, 0);

        // Basic object with a string and a numeric value
        send_str("{\"a\":\"b\",\"cc\":12");
        chk_res("basic_open", 0, 0, 0, 0, 0, 0, 1);
        send_char("}");
        chk_res("basic_done", 0, 2, 2, 12, 1, 0, 0);
        idle_cycle();
        chk_res("basic_pulse_drop", 0, 2, 2, 12, 0, 0, 0);

        // Empty object, then whitespace-separated tokens
        do_reset();
        send_str("{}");
        chk_res("empty", 0, 0, 0, 0, 1, 0, 0);
        send_str("{ \"k\" : 7 , \"z\":\"q\" }");
        chk_res("spaces", 0, 2, 2, 7, 1, 0, 0);

        // Numeric overflow with NUM_W=8
        do_reset();
        send_str("{\"n\":5}");
        chk_res("n8_first", 1, 1, 1, 5, 1, 0, 0);
        send_str("{\"n\":25");
        send_char("6");
        chk_res("n8_overflow", 1, 1, 1, 5, 0, 1, 0);
        send_char("}");
        chk_res("n8_after_err", 1, 1, 1, 5, 0, 0, 0);
        send_str("{\"n\":255}");
        chk_res("n8_max", 1, 1, 1, 255, 1, 0, 0);

        // Key length boundary: 16 ids accepted, 17th rejected
        do_reset();
        send_str("{\"aaaaaaaaaaaaaaaa\":1}");
        chk_res("key16", 0, 1, 1, 1, 1, 0, 0);
        send_str("{\"aaaaaaaaaaaaaaaa");
        chk_res("key16_open", 0, 1, 1, 1, 0, 0, 1);
        send_char("a");
        chk_res("key17", 0, 1, 1, 1, 0, 1, 0);
        send_str("\":2}");
        chk_res("key17_tail", 0, 1, 1, 1, 0, 0, 0);

        // Trailing comma, leading zero, empty key, '{' inside object
        send_str("{\"a\":1,");
        send_char("}");
        chk_res("trail_comma", 0, 1, 1, 1, 0, 1, 0);
        send_str("{\"a\":0");
        send_char("1");
        chk_res("lead_zero", 0, 1, 1, 1, 0, 1, 0);
        send_str("{\"\"");
        chk_res("empty_key", 0, 1, 1, 1, 0, 1, 0);
        send_str("{\"a\"{");
        chk_res("brace_in_obj", 0, 1, 1, 1, 0, 1, 0);
        send_str("\"b\":1}");
        chk_res("brace_no_restart", 0, 1, 1, 1, 0, 0, 0);
        send_str("{\"a\":0,\"b\":\"c\",\"d\":40000,\"e\":30000}");
        chk_res("sum_saturate", 0, 4, 4, 65535, 1, 0, 0);

        // Space rejected when ALLOW_WS=0
        do_reset();
        send_char("{");
        send_char(" ");
        chk_res("nws_space", 2, 0, 0, 0, 0, 1, 0);
        send_str("{\"a\":1}");
        chk_res("nws_ok", 2, 1, 1, 1, 1, 0, 0);

        // Idle cycles interleaved with characters
        do_reset();
        send_gapped("{\"ab\":34,\"c\":\"d\"");
        idle_cycle();
        chk_res("gap_hold", 0, 0, 0, 0, 0, 0, 1);
        send_char("}");
        chk_res("gap_done", 0, 2, 2, 34, 1, 0, 0);
        idle_cycle();
        chk_res("gap_pulse_drop", 0, 2, 2, 34, 0, 0, 0);

        // Reset mid-object discards it and clears outputs
        do_reset();
        send_str("{\"x\":9}");
        chk_res("pre_reset", 0, 1, 1, 9, 1, 0, 0);
        send_str("{\"a\":\"b\"");
        chk_res("pre_reset_busy", 0, 1, 1, 9, 0, 0, 1);
        do_reset();
        chk_res("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        send_str("{\"x\":3}");
        chk_res("post_reset", 0, 1, 1, 3, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
